// File: rtl/pifo_pkg.sv
// Shared definitions for the root PIFO element: field positions, widths,
// pack/unpack helpers and the wrap-aware rank comparison.
package pifo_pkg;

  localparam int BUFFER_ADDR_WIDTH = 12;
  localparam int PIFO_RANK_WIDTH   = 18;
  localparam int PIFO_ROOT_WIDTH   = 32;
  localparam int FLOW_ID_WIDTH     = 4;
  localparam int PKT_LEN_WIDTH     = 16;
  localparam int LEN_SHIFT         = 6;
  localparam int CLAMP_COUNT_WIDTH = 16;

  localparam int VALID_POS      = 31;
  localparam int OVERFLOW_POS   = 30;
  localparam int RANK_START_POS = 12;
  localparam int RANK_END_POS   = 29;

  // Extended rank: the epoch bit on top of the rank, so wrap-around is a plain add.
  localparam int EXT_WIDTH = PIFO_RANK_WIDTH + 1;

  typedef logic [EXT_WIDTH-1:0] ext_rank_t;

  typedef struct packed {
    logic                         valid;
    logic                         overflow;
    logic [PIFO_RANK_WIDTH-1:0]   rank;
    logic [BUFFER_ADDR_WIDTH-1:0] addr;
  } pifo_elem_t;

  function automatic logic [PIFO_ROOT_WIDTH-1:0] pack_elem(
    input ext_rank_t                    rank_ext,
    input logic [BUFFER_ADDR_WIDTH-1:0] addr
  );
    pifo_elem_t e;
    e.valid    = 1'b1;
    e.overflow = rank_ext[EXT_WIDTH-1];
    e.rank     = rank_ext[PIFO_RANK_WIDTH-1:0];
    e.addr     = addr;
    return e;
  endfunction

  function automatic pifo_elem_t unpack_elem(input logic [PIFO_ROOT_WIDTH-1:0] word);
    return pifo_elem_t'(word);
  endfunction

  // Serial-number compare: a is strictly after b within half the extended space.
  function automatic logic rank_after(input ext_rank_t a, input ext_rank_t b);
    ext_rank_t d;
    d = a - b;
    return ~d[EXT_WIDTH-1] & (d != '0);
  endfunction

endpackage

// File: rtl/pifo_flow_finish_table.sv
// Per-flow finish-time table: valid bit plus extended finish rank, one read
// and one write port; a same-cycle write to the read address is forwarded.
module pifo_flow_finish_table #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] finish_q [DEPTH];
  logic                  fwd_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_addr] <= 1'b1;
    end
  end

  // Finish values need no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      finish_q[wr_addr] <= wr_data;
    end
  end

  assign fwd_hit = wr_en && (wr_addr == rd_addr);

  always_comb begin
    rd_valid = valid_q[rd_addr];
    rd_data  = finish_q[rd_addr];
    if (fwd_hit) begin
      rd_valid = 1'b1;
      rd_data  = wr_data;
    end
  end

endmodule

// File: rtl/pifo_rank_enqueue.sv
// Root PIFO feeder: assigns start-time-fair-queuing ranks per flow, inserts
// packed elements into the calendar and tracks virtual time from its pops.
module pifo_rank_enqueue
  import pifo_pkg::*;
#(
  parameter int BUFFER_ADDR_WIDTH = pifo_pkg::BUFFER_ADDR_WIDTH,
  parameter int PIFO_RANK_WIDTH   = pifo_pkg::PIFO_RANK_WIDTH,
  parameter int PIFO_ROOT_WIDTH   = pifo_pkg::PIFO_ROOT_WIDTH,
  parameter int FLOW_ID_WIDTH     = pifo_pkg::FLOW_ID_WIDTH,
  parameter int PKT_LEN_WIDTH     = pifo_pkg::PKT_LEN_WIDTH,
  parameter int LEN_SHIFT         = pifo_pkg::LEN_SHIFT
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         s_desc_valid,
  output logic                         s_desc_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] s_desc_buffer_addr,
  input  logic [FLOW_ID_WIDTH-1:0]     s_desc_flow_id,
  input  logic [PKT_LEN_WIDTH-1:0]     s_desc_pkt_len,
  input  logic                         s_calendar_full,
  input  logic                         s_pop_en,
  input  logic [PIFO_ROOT_WIDTH-1:0]   s_calendar_top,
  output logic [PIFO_ROOT_WIDTH-1:0]   m_axis_pifo_info_root,
  output logic                         m_axis_insert_en,
  output logic [PIFO_ROOT_WIDTH-1:0]   m_axis_global_pifo,
  output logic [CLAMP_COUNT_WIDTH-1:0] m_clamp_count
);

  localparam ext_rank_t CLAMP_SPAN  = ext_rank_t'(1 << (PIFO_RANK_WIDTH - 1));
  localparam ext_rank_t CLAMP_LIMIT = CLAMP_SPAN - ext_rank_t'(1);

  logic                         take;
  logic                         tbl_rd_valid;
  ext_rank_t                    tbl_rd_data;

  logic                         s1_valid;
  logic [BUFFER_ADDR_WIDTH-1:0] s1_addr;
  logic [FLOW_ID_WIDTH-1:0]     s1_flow;
  logic [PKT_LEN_WIDTH-1:0]     s1_len;
  logic                         s1_entry_valid;
  ext_rank_t                    s1_fin;

  logic [PIFO_RANK_WIDTH-1:0]   vt;
  logic                         vt_epoch;
  ext_rank_t                    vt_ext;

  ext_rank_t                    diff;
  logic                         ahead;
  logic                         clamp;
  logic [PKT_LEN_WIDTH-1:0]     len_cost;
  ext_rank_t                    cost_ext;
  ext_rank_t                    start_ext;
  ext_rank_t                    finish_ext;

  pifo_elem_t                   top_elem;
  logic                         unused_top_addr;

  assign s_desc_ready = ~s_calendar_full & rstn;
  assign take         = s_desc_valid & s_desc_ready;

  pifo_flow_finish_table #(
    .ADDR_WIDTH (FLOW_ID_WIDTH),
    .DATA_WIDTH (EXT_WIDTH)
  ) u_finish_table (
    .clk      (clk),
    .rstn     (rstn),
    .rd_addr  (s_desc_flow_id),
    .rd_valid (tbl_rd_valid),
    .rd_data  (tbl_rd_data),
    .wr_en    (s1_valid),
    .wr_addr  (s1_flow),
    .wr_data  (finish_ext)
  );

  // Stage 1: capture the descriptor with its (possibly forwarded) flow state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid       <= 1'b0;
      s1_addr        <= '0;
      s1_flow        <= '0;
      s1_len         <= '0;
      s1_entry_valid <= 1'b0;
      s1_fin         <= '0;
    end else begin
      s1_valid <= take;
      if (take) begin
        s1_addr        <= s_desc_buffer_addr;
        s1_flow        <= s_desc_flow_id;
        s1_len         <= s_desc_pkt_len;
        s1_entry_valid <= tbl_rd_valid;
        s1_fin         <= tbl_rd_data;
      end
    end
  end

  assign vt_ext = {vt_epoch, vt};

  // Stage 2: start = max(finish, vt) in serial order, bounded to half a window ahead.
  always_comb begin
    diff      = s1_fin - vt_ext;
    ahead     = s1_entry_valid & rank_after(s1_fin, vt_ext);
    clamp     = ahead & (diff >= CLAMP_SPAN);
    len_cost  = s1_len >> LEN_SHIFT;
    cost_ext  = (len_cost == '0) ? ext_rank_t'(1) : ext_rank_t'(len_cost);
    start_ext = vt_ext;
    if (clamp) begin
      start_ext = vt_ext + CLAMP_LIMIT;
    end else if (ahead) begin
      start_ext = s1_fin;
    end
    finish_ext = start_ext + cost_ext;
  end

  assign m_axis_insert_en      = s1_valid;
  assign m_axis_pifo_info_root = s1_valid ? pack_elem(start_ext, s1_addr) : '0;

  assign top_elem        = unpack_elem(s_calendar_top);
  assign unused_top_addr = ^top_elem.addr;

  // Pops update vt at the edge, so a concurrent stage 2 still sees the old value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vt       <= '0;
      vt_epoch <= 1'b0;
    end else if (s_pop_en && top_elem.valid) begin
      vt       <= top_elem.rank;
      vt_epoch <= top_elem.overflow;
    end
  end

  assign m_axis_global_pifo = {1'b0, vt_epoch, vt, {BUFFER_ADDR_WIDTH{1'b0}}};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_clamp_count <= '0;
    end else if (s1_valid && clamp && (m_clamp_count != '1)) begin
      m_clamp_count <= m_clamp_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pifo_rank_enqueue.sv
// Table-driven bench for pifo_rank_enqueue with a scoreboard of expected
// insert elements and the cycle each one is due.
module tb_pifo_rank_enqueue;
  import pifo_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_desc_valid;
  logic        s_desc_ready;
  logic [11:0] s_desc_buffer_addr;
  logic [3:0]  s_desc_flow_id;
  logic [15:0] s_desc_pkt_len;
  logic        s_calendar_full;
  logic        s_pop_en;
  logic [31:0] s_calendar_top;
  logic [31:0] m_axis_pifo_info_root;
  logic        m_axis_insert_en;
  logic [31:0] m_axis_global_pifo;
  logic [15:0] m_clamp_count;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] elem;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic        desc;
    logic [3:0]  flow;
    logic [15:0] len;
    logic [11:0] addr;
    logic [31:0] exp_elem;
    logic        pop;
    logic [31:0] top;
    logic [31:0] exp_global;
  } vec_t;

  vec_t vecs[20];

  pifo_rank_enqueue dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .s_desc_valid          (s_desc_valid),
    .s_desc_ready          (s_desc_ready),
    .s_desc_buffer_addr    (s_desc_buffer_addr),
    .s_desc_flow_id        (s_desc_flow_id),
    .s_desc_pkt_len        (s_desc_pkt_len),
    .s_calendar_full       (s_calendar_full),
    .s_pop_en              (s_pop_en),
    .s_calendar_top        (s_calendar_top),
    .m_axis_pifo_info_root (m_axis_pifo_info_root),
    .m_axis_insert_en      (m_axis_insert_en),
    .m_axis_global_pifo    (m_axis_global_pifo),
    .m_clamp_count         (m_clamp_count)
  );

  // Every insert strobe must match the oldest expected element, on its due cycle.
  always @(negedge clk) begin
    if (rstn && m_axis_insert_en) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_insert got=%h expected no insert", m_axis_pifo_info_root);
      end else begin
        mon_e = sb.pop_front();
        if (m_axis_pifo_info_root !== mon_e.elem) begin
          errors++;
          $display("[TB] FAIL insert_elem got=%h expected=%h", m_axis_pifo_info_root, mon_e.elem);
        end
        checks++;
        if (cyc != mon_e.due) begin
          errors++;
          $display("[TB] FAIL insert_latency got_cycle=%0d expected_cycle=%0d", cyc, mon_e.due);
        end
      end
    end
  end

  function automatic vec_t mkDesc(input logic [3:0] flow, input logic [15:0] len,
                                  input logic [11:0] addr, input logic [31:0] exp_elem,
                                  input logic [31:0] glob);
    vec_t v;
    v = '{1'b1, flow, len, addr, exp_elem, 1'b0, 32'h0, glob};
    return v;
  endfunction

  function automatic vec_t mkPop(input logic [31:0] top, input logic [31:0] glob);
    vec_t v;
    v = '{1'b0, 4'd0, 16'd0, 12'h0, 32'h0, 1'b1, top, glob};
    return v;
  endfunction

  function automatic vec_t mkIdle(input logic [31:0] glob);
    vec_t v;
    v = '{1'b0, 4'd0, 16'd0, 12'h0, 32'h0, 1'b0, 32'h0, glob};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one cycle (caller sits just after a rising edge) and checks the global word.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    s_desc_valid       = v.desc;
    s_desc_flow_id     = v.flow;
    s_desc_pkt_len     = v.len;
    s_desc_buffer_addr = v.addr;
    s_pop_en           = v.pop;
    s_calendar_top     = v.top;
    if (v.desc) begin
      e.elem = v.exp_elem;
      e.due  = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    checkOutput("global_word", m_axis_global_pifo, v.exp_global);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    vecs[0]  = mkDesc(4'd3, 16'd640, 12'h055, 32'h8000_0055, 32'h0);
    vecs[1]  = mkDesc(4'd3, 16'd64,  12'h056, 32'h8000_A056, 32'h0);
    vecs[2]  = mkDesc(4'd4, 16'd640, 12'h101, 32'h8000_0101, 32'h0);
    vecs[3]  = mkDesc(4'd4, 16'd128, 12'h102, 32'h8000_A102, 32'h0);
    vecs[4]  = mkDesc(4'd1, 16'd64,  12'h011, 32'h8000_0011, 32'h0);
    vecs[5]  = mkDesc(4'd2, 16'd64,  12'h012, 32'h8000_0012, 32'h0);
    vecs[6]  = mkDesc(4'd1, 16'd64,  12'h013, 32'h8000_1013, 32'h0);
    vecs[7]  = mkDesc(4'd2, 16'd64,  12'h014, 32'h8000_1014, 32'h0);
    vecs[8]  = mkDesc(4'd8, 16'd64,  12'h020, 32'h8000_0020, 32'h0);
    vecs[9]  = mkPop(32'h8006_4000, 32'h0);
    vecs[10] = mkDesc(4'd9, 16'd0,   12'h030, 32'h8006_4030, 32'h0006_4000);
    vecs[11] = mkDesc(4'd8, 16'd64,  12'h031, 32'h8006_4031, 32'h0006_4000);
    vecs[12] = mkDesc(4'd9, 16'd63,  12'h032, 32'h8006_5032, 32'h0006_4000);
    vecs[13] = mkPop(32'h0003_2000, 32'h0006_4000);
    vecs[14] = mkIdle(32'h0006_4000);
    vecs[15] = mkPop(32'hBFFF_F000, 32'h0006_4000);
    vecs[16] = mkIdle(32'h3FFF_F000);
    vecs[17] = mkDesc(4'd6, 16'd128, 12'h040, 32'hBFFF_F040, 32'h3FFF_F000);
    vecs[18] = mkDesc(4'd6, 16'd128, 12'h041, 32'hC000_1041, 32'h3FFF_F000);
    vecs[19] = mkIdle(32'h3FFF_F000);

    rstn = 1'b0;
    s_desc_valid = 1'b0;
    s_desc_buffer_addr = '0;
    s_desc_flow_id = '0;
    s_desc_pkt_len = '0;
    s_calendar_full = 1'b0;
    s_pop_en = 1'b0;
    s_calendar_top = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", 32'(s_desc_ready), 32'h0);
    checkOutput("reset_insert_en", 32'(m_axis_insert_en), 32'h0);
    checkOutput("reset_root", m_axis_pifo_info_root, 32'h0);
    checkOutput("reset_global", m_axis_global_pifo, 32'h0);
    checkOutput("reset_clamp", 32'(m_clamp_count), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(s_desc_ready), 32'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) applyStimulus(vecs[i]);

    // Full rises while a descriptor sits in stage 1: it must still be inserted.
    s_desc_valid = 1'b1;
    s_desc_flow_id = 4'd11;
    s_desc_pkt_len = 16'd64;
    s_desc_buffer_addr = 12'h051;
    e.elem = 32'hBFFF_F051;
    e.due = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    s_calendar_full = 1'b1;
    s_desc_flow_id = 4'd10;
    s_desc_buffer_addr = 12'h050;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("ready_while_full", 32'(s_desc_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    s_calendar_full = 1'b0;
    e.elem = 32'hBFFF_F050;
    e.due = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    checkOutput("ready_after_full", 32'(s_desc_ready), 32'h1);
    @(posedge clk);
    #1;
    s_desc_valid = 1'b0;
    @(negedge clk);
    checkOutput("clamp_count_before", 32'(m_clamp_count), 32'h0);
    @(posedge clk);
    #1;

    // Clamp: flow 7 ends 2^17 ahead of vt once vt is pulled back by a pop.
    applyStimulus(mkPop(32'hA000_0000, 32'h3FFF_F000));
    applyStimulus(mkDesc(4'd7, 16'd640, 12'h060, 32'hA000_0060, 32'h2000_0000));
    applyStimulus(mkPop(32'h8000_A000, 32'h2000_0000));
    applyStimulus(mkDesc(4'd7, 16'd64, 12'h061, 32'hA000_9061, 32'h0000_A000));
    applyStimulus(mkIdle(32'h0000_A000));
    applyStimulus(mkIdle(32'h0000_A000));
    checkOutput("clamp_count_after", 32'(m_clamp_count), 32'h1);

    // A second reset must clear vt, the counter and every flow entry.
    rstn = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rereset_global", m_axis_global_pifo, 32'h0);
    checkOutput("rereset_clamp", 32'(m_clamp_count), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    applyStimulus(mkDesc(4'd3, 16'd64, 12'h070, 32'h8000_0070, 32'h0));
    applyStimulus(mkIdle(32'h0));

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_insert got=none expected=%h", e.elem);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
